// File: rtl/test_master_slave9_peer_pkg.sv
// Shared types for the TestMasterSlave9 peer driver: the project-wide integer type
// and the two-section enum used by the peer FSM.
package top_level_types;
  typedef logic [31:0] int_t;
endpackage

package testmasterslave9_peer_types;
  import top_level_types::*;

  typedef enum logic {
    section_a = 1'b0,
    section_b = 1'b1
  } Sections;

  localparam int WAIT_CYCLES_MAX = 255;

  // Two's-complement increment; wraps 0x7FFFFFFF to 0x80000000.
  function automatic int_t next_val(input int_t v);
    return v + 32'd1;
  endfunction
endpackage

// File: rtl/test_master_slave9_peer.sv
// Peer driver for the slave-with-sync link: emits a value plus a one-cycle strobe,
// waits WAIT_CYCLES cycles, then derives the next value from the partner's output.
module test_master_slave9_peer
  import top_level_types::*;
  import testmasterslave9_peer_types::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int START_VAL   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_m_in,
  output logic [31:0] o_m_out,
  output logic        o_m_out_sync,
  output logic        o_section_out,
  output logic [31:0] o_txn_count
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
    $error("test_master_slave9_peer: WAIT_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(WAIT_CYCLES - 1);
  localparam int_t       VAL_INIT = 32'(START_VAL);

  Sections    r_section;
  logic [7:0] r_cnt;
  int_t       r_val;
  int_t       r_m_out;
  logic       r_m_out_sync;
  int_t       r_txn_count;
  logic       w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_section    <= section_a;
      r_cnt        <= 8'd0;
      r_val        <= VAL_INIT;
      r_m_out      <= 32'd0;
      r_m_out_sync <= 1'b0;
      r_txn_count  <= 32'd0;
    end else begin
      case (r_section)
        section_a: begin
          r_m_out      <= r_val;
          r_m_out_sync <= 1'b1;
          r_txn_count  <= r_txn_count + 32'd1;
          r_cnt        <= 8'd0;
          r_section    <= section_b;
        end
        default: begin
          r_m_out_sync <= 1'b0;
          // i_m_in only matters on the final wait cycle; earlier values are ignored.
          if (w_cnt_last) begin
            r_val     <= next_val(i_m_in);
            r_cnt     <= 8'd0;
            r_section <= section_a;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign o_m_out       = r_m_out;
  assign o_m_out_sync  = r_m_out_sync;
  assign o_section_out = r_section;
  assign o_txn_count   = r_txn_count;

endmodule

// File: tb/tb_test_master_slave9_peer.sv
// Randomized bench for the peer driver: three parameterizations against a
// transaction-level model built from edge counts since reset.
module tb_test_master_slave9_peer;
  import testmasterslave9_peer_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_in0 = 32'd0, m_in2 = 32'd0;
  logic [31:0] out0, out1, out2, txn0, txn1, txn2;
  logic        sync0, sync1, sync2, sec0, sec1, sec2;

  always #5 clk = ~clk;

  test_master_slave9_peer #(.WAIT_CYCLES(2), .START_VAL(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_m_in(m_in0), .o_m_out(out0),
    .o_m_out_sync(sync0), .o_section_out(sec0), .o_txn_count(txn0));
  test_master_slave9_peer #(.WAIT_CYCLES(1), .START_VAL(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_m_in(out1), .o_m_out(out1),
    .o_m_out_sync(sync1), .o_section_out(sec1), .o_txn_count(txn1));
  test_master_slave9_peer #(.WAIT_CYCLES(2), .START_VAL(-5)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_m_in(m_in2), .o_m_out(out2),
    .o_m_out_sync(sync2), .o_section_out(sec2), .o_txn_count(txn2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: k = edges since reset; strobe on k = 1 mod (W+1), capture on k = 0 mod (W+1).
  int          mw[3] = '{2, 1, 2};
  logic [31:0] ms[3] = '{32'd0, 32'd0, 32'hFFFF_FFFB};
  int          mk[3];
  logic [31:0] mval[3], mout[3], mtxn[3];
  logic        msync[3];
  logic        prev_sync1 = 1'b0;

  function automatic void mstep(input int i, input logic r, input logic [31:0] mi);
    if (r) begin
      mk[i] = 0; mval[i] = ms[i]; mout[i] = 0; msync[i] = 1'b0; mtxn[i] = 0;
    end else begin
      mk[i]++;
      msync[i] = ((mk[i] - 1) % (mw[i] + 1)) == 0;
      if (msync[i]) begin
        mout[i] = mval[i];
        mtxn[i] = mtxn[i] + 32'd1;
      end
      if (mk[i] % (mw[i] + 1) == 0) mval[i] = mi + 32'd1;
    end
  endfunction

  function automatic logic msec(input int i);
    return (mk[i] % (mw[i] + 1) == 0) ? section_a : section_b;
  endfunction

  task automatic compare_all();
    chk("d0_out", out0, mout[0]);   chk("d0_sync", {31'd0, sync0}, {31'd0, msync[0]});
    chk("d0_txn", txn0, mtxn[0]);   chk("d0_sec", {31'd0, sec0}, {31'd0, msec(0)});
    chk("d1_out", out1, mout[1]);   chk("d1_sync", {31'd0, sync1}, {31'd0, msync[1]});
    chk("d1_txn", txn1, mtxn[1]);   chk("d1_sec", {31'd0, sec1}, {31'd0, msec(1)});
    chk("d2_out", out2, mout[2]);   chk("d2_sync", {31'd0, sync2}, {31'd0, msync[2]});
    chk("d2_txn", txn2, mtxn[2]);   chk("d2_sec", {31'd0, sec2}, {31'd0, msec(2)});
    chk("d1_sync_pair", {31'd0, sync1 & prev_sync1}, 32'd0);
    prev_sync1 = sync1;
  endtask

  task automatic step(input logic r, input logic [31:0] a0, input logic [31:0] a2);
    logic [31:0] loop_in;
    @(negedge clk);
    rst = r; m_in0 = a0; m_in2 = a2;
    #1 loop_in = out1;
    @(posedge clk);
    mstep(0, r, a0); mstep(1, r, loop_in); mstep(2, r, a2);
    #1 compare_all();
  endtask

  function automatic logic [31:0] pick(input int k, input int w);
    if ((k + 1) % (w + 1) == 0)
      case ($urandom_range(0, 3))
        0: return 32'h7FFF_FFFF;
        1: return 32'd7;
        default: return $urandom;
      endcase
    case ($urandom_range(0, 2))
      0: return 32'd5;
      1: return 32'd99;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1'b1, 32'd10, 32'd10);
    chk("rst_out", out0, 32'd0);
    chk("rst_txn", txn0, 32'd0);
    chk("rst_sec", {31'd0, sec0}, {31'd0, section_a});
    for (int e = 1; e <= 7; e++) begin
      step(1'b0, 32'd10, 32'd10);
      if (e == 1 || e == 4 || e == 7) begin
        chk("p1_sync", {31'd0, sync0}, 32'd1);
        chk("p1_out", out0, (e == 1) ? 32'd0 : 32'd11);
        chk("p1_txn", txn0, 32'(e / 3 + 1));
      end
      if (e % 2 == 1) chk("lb_out", out1, 32'((e - 1) / 2));
      if (e == 1) chk("sv_out", out2, 32'hFFFF_FFFB);
      if (e == 3) chk("sv_sec", {31'd0, sec2}, {31'd0, section_a});
    end
    // Directed wrap: capture 0x7FFFFFFF, expect 0x80000000 on the next strobe.
    while (mk[0] % 3 != 2) step(1'b0, 32'd5, 32'd5);
    step(1'b0, 32'h7FFF_FFFF, 32'd7);
    step(1'b0, 32'd99, 32'd99);
    chk("wrap_out", out0, 32'h8000_0000);
    chk("glitch_out", out2, 32'd8);
    // Reset mid-section_b, then a reset that lands on a transaction boundary.
    step(1'b0, 32'd1, 32'd1);
    step(1'b1, 32'd1, 32'd1);
    chk("midrst_out", out0, 32'd0);
    chk("midrst_sync", {31'd0, sync0}, 32'd0);
    step(1'b0, 32'd3, 32'd3);
    chk("post_rst_out", out2, 32'hFFFF_FFFB);
    step(1'b0, 32'd3, 32'd3);
    step(1'b1, 32'd3, 32'd3);
    chk("bound_rst_sync", {31'd0, sync0}, 32'd0);
    for (int c = 0; c < 400; c++)
      step(($urandom_range(0, 39) == 0), pick(mk[0], mw[0]), pick(mk[2], mw[2]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_master_slave9_peer.md
# test_master_slave9_peer

Peer driver for the slave-with-sync channel pair of the TestMasterSlave9 family. It sits on the opposite end of the link: it produces the integer value plus one-cycle sync strobe that the slave side consumes, and it samples the slave side's integer output to compute the next value. It is a two-section state machine with a wait counter and a transaction counter, used as the stimulus/partner block in section-based master/slave test designs.

## Interface
- `WAIT_CYCLES`, default 2: cycles spent in `section_b` per transaction; legal range 1..255.
- `START_VAL`, default 0: first value driven after reset.
- `clk` input 1: single clock, all state updates on its rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `m_in` input 32 (integer): value from the partner's slave output; sampled only in `section_b`.
- `m_out` output 32 (integer): value presented to the partner's slave input.
- `m_out_sync` output 1: one-cycle strobe qualifying `m_out`.
- `section_out` output `Sections`: current section, for debug and scoreboarding.
- `txn_count` output 32: number of sync strobes issued since reset.

## Operation
- State: `section` (`Sections`: `section_a`, `section_b`), `cnt` (8-bit), `val` (integer), plus the registered outputs.
- Reset, applied at a rising edge with `rst`=1:
  - `section`=`section_a`, `cnt`=0, `val`=`START_VAL`.
  - `m_out`=0, `m_out_sync`=0, `txn_count`=0.
  - `section_out`=`section_a`.
- `section_a` takes one cycle:
  - `m_out`<=`val`, `m_out_sync`<=1, `txn_count`<=`txn_count`+1.
  - `cnt`<=0, `section`<=`section_b`.
- `section_b`:
  - `m_out_sync`<=0 and `m_out` holds its value.
  - If `cnt`==`WAIT_CYCLES`-1: `val`<=`m_in`+1, `section`<=`section_a`, `cnt`<=0.
  - Otherwise: `cnt`<=`cnt`+1.
- Arithmetic:
  - `m_in`+1 is 32-bit two's-complement with wrap; 2147483647 becomes -2147483648.
  - `txn_count` wraps from 0xFFFFFFFF to 0.
- `m_in` is ignored in `section_a` and in `section_b` cycles other than the last.
- `section_out` reflects the registered `section`.

## Timing
- Only one transaction is ever outstanding, so no back-pressure exists.
- First rising edge with `rst`=0 (block in `section_a`):
  - `m_out`=`START_VAL` and `m_out_sync`=1 become visible after that edge.
  - `txn_count`=1.
- Transaction period is `WAIT_CYCLES`+1 cycles, so strobes are spaced `WAIT_CYCLES`+1 edges apart.
- `m_out_sync` is high for exactly one cycle per transaction and is never high on two consecutive cycles, including when `WAIT_CYCLES`=1.
- `m_in` is captured at the edge that ends the last `section_b` cycle. The resulting `m_out` appears one edge later, together with the next strobe.
- Reset asserted mid-`section_b`:
  - The next edge applies the reset values; `m_out_sync` is 0 even if a strobe was due.
  - No partial `val` update survives.
- `rst` high and a transaction boundary on the same edge: reset wins.

## Structure
- Shared package `testmasterslave9_peer_types`:
  - enum `Sections` {`section_a`, `section_b`}.
  - constant `WAIT_CYCLES_MAX`=255.
- Project-wide types come from `top_level_types`.
- Single flat module with one clocked process and no sub-module; the wait counter is too small to justify one.
- Elaboration check: fail if `WAIT_CYCLES` < 1 or `WAIT_CYCLES` > 255.

## Test plan
- Reset release with defaults and `m_in` held at 10:
  - Strobes at edges 1, 4, 7.
  - `m_out` at those edges is 0, 11, 11.
  - `txn_count` at those edges is 1, 2, 3.
- `WAIT_CYCLES`=1, `m_in` tracking `m_out` through a loopback:
  - `m_out` sequence 0, 1, 2, 3 with strobes on alternate cycles.
  - `m_out_sync` is never high on two consecutive cycles.
- `m_in`=2147483647 at the capture edge -> next `m_out`=-2147483648 with strobe.
- `m_in` toggled 5/99 on non-capture `section_b` cycles, 7 at the capture edge -> next `m_out`=8; the glitch values have no effect.
- `rst` pulsed high for one cycle during `section_b` -> next edge shows `m_out`=0, sync 0, `txn_count`=0, `section_out`=`section_a`. The first post-reset strobe carries `START_VAL`.
- `START_VAL`=-5 -> first strobe `m_out`=-5; `section_out` alternates `section_a`, `section_b`, `section_b`.
